// File: rtl/microwave_pkg.sv
// microwave_pkg: shared FSM states and BCD constants for the keypad entry path
package microwave_pkg;
  typedef enum logic [2:0] {IDLE, DEBOUNCE, CAPTURE, WAIT_RELEASE, LOAD, LOCKED} state_t;
  localparam int BCD_W = 4;
  localparam int BCD_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: counts consecutive cycles of a stable level, done on the last one
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic match,
  input  logic restart,
  output logic done
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign done = match && !restart && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (restart || !match || done) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounced BCD keypad entry handed to the countdown timer.
// Define ENTRY_MMSS_CHECK_EN to reject starts whose seconds-tens digit exceeds 5.
module keypad_entry_ctrl
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      enc_enablen,
  input  logic [BCD_W-1:0]          enc_bcd,
  input  logic                      enc_idle,
  input  logic                      clear,
  input  logic                      start_req,
  input  logic                      timer_busy,
  output logic                      load_valid,
  input  logic                      load_ready,
  output logic [BCD_W*DIGITS-1:0]   time_digits,
  output logic [2:0]                digit_count,
  output logic                      entry_err
);
  state_t state, state_n;
  logic [BCD_W-1:0] latched;
  logic first_lock, match, restart, done, clr_ok, start_ok, reject;
  assign clr_ok = clear && (state == IDLE || state == DEBOUNCE || state == CAPTURE || state == WAIT_RELEASE);
  assign start_ok = state == IDLE && !clear && start_req && digit_count != '0 && !timer_busy;
`ifdef ENTRY_MMSS_CHECK_EN
  assign reject = time_digits[2*BCD_W-1:BCD_W] > BCD_W'(SEC_TENS_MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) entry_err <= 1'b0;
    else entry_err <= start_ok && reject;
`else
  assign reject = 1'b0;
  assign entry_err = 1'b0;
`endif
  // one counter serves both the press (IDLE/DEBOUNCE) and release (WAIT_RELEASE) windows
  assign match = state == IDLE ? !enc_idle
               : state == DEBOUNCE ? (!enc_idle && enc_bcd == latched)
               : state == WAIT_RELEASE && enc_idle;
  assign restart = clr_ok || (start_ok && !reject);
  assign load_valid = state == LOAD;
  assign enc_enablen = state == LOAD || state == LOCKED;
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk), .rst_n(rst_n), .match(match), .restart(restart), .done(done)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         state_n = (start_ok && !reject) ? LOAD : match ? DEBOUNCE : IDLE;
      DEBOUNCE:     state_n = !match ? IDLE : done ? CAPTURE : DEBOUNCE;
      CAPTURE:      state_n = WAIT_RELEASE;
      WAIT_RELEASE: state_n = done ? IDLE : WAIT_RELEASE;
      LOAD:         state_n = load_ready ? LOCKED : LOAD;
      LOCKED:       state_n = (!first_lock && !timer_busy) ? IDLE : LOCKED;
      default:      state_n = IDLE;
    endcase
    if (clr_ok) state_n = enc_idle ? IDLE : WAIT_RELEASE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      latched     <= '0;
      time_digits <= '0;
      digit_count <= '0;
      first_lock  <= 1'b0;
    end else begin
      state      <= state_n;
      first_lock <= state == LOAD;
      if (state == IDLE && match) latched <= enc_bcd;
      if (clr_ok || (state == LOAD && load_ready)) begin
        time_digits <= '0;
        digit_count <= '0;
      end else if (state == CAPTURE && latched <= BCD_W'(BCD_MAX)) begin
        time_digits <= {time_digits[BCD_W*DIGITS-BCD_W-1:0], latched};
        digit_count <= digit_count == 3'(DIGITS) ? digit_count : digit_count + 3'd1;
      end
    end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: scoreboard bench with a digit-entry reference model
module tb_keypad_entry_ctrl;
  localparam int D = 4;
  logic clk, rst_n, enc_enablen, enc_idle, clear, start_req, timer_busy;
  logic load_valid, load_ready, entry_err;
  logic [3:0] enc_bcd;
  logic [15:0] time_digits;
  logic [2:0] digit_count;
  typedef struct packed {logic [15:0] td; logic [2:0] cnt;} ent_t;
  ent_t exp_q[$];
  logic [15:0] load_q[$];
  logic [15:0] mtd, prev_td;
  logic [2:0] prev_cnt;
  int mcnt, total, bad, err_seen, exp_err;

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(D), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .enc_enablen(enc_enablen), .enc_bcd(enc_bcd),
    .enc_idle(enc_idle), .clear(clear), .start_req(start_req), .timer_busy(timer_busy),
    .load_valid(load_valid), .load_ready(load_ready), .time_digits(time_digits),
    .digit_count(digit_count), .entry_err(entry_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mpush(input logic [15:0] t, input int c);
    if (t != mtd || c != mcnt) exp_q.push_back('{td: t, cnt: 3'(c)});
    mtd = t;
    mcnt = c;
  endtask

  task automatic mshift(input logic [3:0] k);
    mpush(16'((32'(mtd) << 4) | 32'(k)), mcnt < 4 ? mcnt + 1 : 4);
  endtask

  task automatic mzero();
    mpush(16'h0, 0);
  endtask

  task automatic press(input logic [3:0] k, input int h, input int g);
    enc_bcd = k; enc_idle = 0; cyc(h);
    enc_idle = 1; enc_bcd = 4'($urandom_range(0, 15)); cyc(g);
  endtask

  // a stable press lasting at least D cycles yields one digit when it is valid BCD
  task automatic key(input logic [3:0] k, input int h);
    if (h >= D && k <= 9) mshift(k);
    press(k, h, 6);
  endtask

  task automatic tclear();
    mzero();
    clear = 1; cyc(1); clear = 0; cyc(1);
  endtask

  task automatic do_start_load(input logic [15:0] e, input int dly);
    int n;
    load_q.push_back(e);
    mzero();
    start_req = 1; cyc(1); start_req = 0;
    n = 0;
    for (int i = 0; i <= dly; i++) begin
      n += int'(load_valid);
      chk("load_hold", time_digits, e);
      if (i == dly) load_ready = 1;
      cyc(1);
    end
    load_ready = 0;
    chk("lv_cycles", n, dly + 1);
    chk("lv_drop", load_valid, 0);
    chk("td_cleared", time_digits, 0);
    chk("enc_locked", enc_enablen, 1);
    cyc(1);
    chk("lock_first", enc_enablen, 1);
    timer_busy = 1;
    cyc(2);
    enc_bcd = 4'd3; enc_idle = 0; cyc(5); enc_idle = 1;
    cyc(3);
    chk("lock_busy", enc_enablen, 1);
    timer_busy = 0; cyc(1);
    chk("unlock", enc_enablen, 0);
    cyc(2);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_td = time_digits;
      prev_cnt = digit_count;
    end else begin
      if (entry_err) err_seen++;
      if (load_valid && load_ready) begin
        if (load_q.size() == 0) begin
          total++; bad++;
          $display("FAIL load_unexpected got=%0h want=none", time_digits);
        end else chk("load_data", time_digits, load_q.pop_front());
      end
      if (time_digits != prev_td || digit_count != prev_cnt) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL entry_unexpected got=%0h/%0d want=none", time_digits, digit_count);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("entry_td", time_digits, e.td);
          chk("entry_cnt", digit_count, e.cnt);
        end
        prev_td = time_digits;
        prev_cnt = digit_count;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int n;
    total = 0; bad = 0; err_seen = 0; exp_err = 0; mtd = 0; mcnt = 0;
    rst_n = 0; enc_bcd = 0; enc_idle = 1; clear = 0; start_req = 0; timer_busy = 0; load_ready = 0;
    #12;
    chk("rst_td", time_digits, 0);
    chk("rst_cnt", digit_count, 0);
    chk("rst_lv", load_valid, 0);
    chk("rst_enc", enc_enablen, 0);
    chk("rst_err", entry_err, 0);
    @(posedge clk); #1 rst_n = 1;
    cyc(1);
    // press-to-update latency is D+1 edges
    mshift(4'd1);
    enc_bcd = 4'd1; enc_idle = 0; cyc(D);
    chk("lat_early", time_digits, 16'h0000);
    cyc(1);
    chk("lat_hit", time_digits, 16'h0001);
    cyc(1); enc_idle = 1; cyc(6);
    key(4'd2, 6); key(4'd3, 6); key(4'd0, 6);
    chk("entry_1230", time_digits, 16'h1230);
    chk("count_4", digit_count, 4);
    key(4'd5, 6);
    chk("entry_2305", time_digits, 16'h2305);
    chk("count_sat", digit_count, 4);
    enc_bcd = 4'd7; enc_idle = 0; cyc(2);
    enc_bcd = 4'd8; cyc(2);
    enc_idle = 1; cyc(6);
    chk("glitch_none", time_digits, 16'h2305);
    key(4'd9, 40);
    chk("held_once", time_digits, 16'h3059);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) tclear();
      key(4'($urandom_range(0, 11)), $urandom_range(1, 8));
    end
    tclear();
    key(4'd0, 5); key(4'd1, 5); key(4'd3, 5); key(4'd0, 5);
    chk("entry_0130", time_digits, 16'h0130);
    do_start_load(16'h0130, 3);
    key(4'd4, 5); key(4'd5, 5);
    mzero();
    clear = 1; start_req = 1; cyc(1); clear = 0; start_req = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin n += int'(load_valid); cyc(1); end
    chk("clr_wins_lv", n, 0);
    chk("clr_wins_td", time_digits, 0);
    start_req = 1; cyc(1); start_req = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin n += int'(load_valid); cyc(1); end
    chk("empty_start", n, 0);
    key(4'd7, 5);
    timer_busy = 1; start_req = 1; cyc(1); start_req = 0; timer_busy = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin n += int'(load_valid); cyc(1); end
    chk("busy_start", n, 0);
    tclear();
    key(4'd1, 5); key(4'd2, 5);
    start_req = 1; cyc(1); start_req = 0;
    chk("pre_rst_lv", load_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_lv", load_valid, 0);
    chk("async_td", time_digits, 0);
    chk("async_enc", enc_enablen, 0);
    load_q.delete(); exp_q.delete(); mtd = 0; mcnt = 0;
    cyc(2); rst_n = 1; cyc(1);
    key(4'd7, 5); key(4'd5, 5);
    chk("entry_0075", time_digits, 16'h0075);
`ifdef ENTRY_MMSS_CHECK_EN
    exp_err = 1;
    start_req = 1; cyc(1); start_req = 0;
    chk("err_pulse", entry_err, 1);
    chk("err_no_load", load_valid, 0);
    cyc(1);
    chk("err_one_cycle", entry_err, 0);
    chk("err_kept", time_digits, 16'h0075);
    tclear();
`else
    do_start_load(16'h0075, 0);
`endif
    key(4'd5, 5); key(4'd9, 5);
    do_start_load(16'h0059, 1);
    cyc(3);
    chk("left_entries", exp_q.size(), 0);
    chk("left_loads", load_q.size(), 0);
    chk("err_pulses", err_seen, exp_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
